// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-bus request/response bundle between fetch and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  ireq_ready,
    input  iresp_valid,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output ireq_ready,
    output iresp_valid,
    output iresp_data
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetcher with redirect and drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        ibus,
  input  logic                redirect_valid,
  input  logic [63:0]         redirect_pc,
  output logic                out_valid,
  output logic [31:0]         out_instr,
  output logic [63:0]         out_pc,
  output logic                out_fault,
  input  logic                out_ready,
  output logic [63:0]         fetch_count
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [63:0] r_out_pc;
  logic        r_out_fault;
  logic [63:0] r_fetch_count;

  logic w_aligned;
  logic w_req_fire;

  assign w_aligned  = (r_pc[1:0] == 2'b00);
  assign w_req_fire = w_aligned && ibus.ireq_ready;

  // Gated by reset so the bus sees no request while the block is held in reset.
  assign ibus.ireq_valid = reset && (r_state == ST_REQ) && w_aligned;
  assign ibus.ireq_addr  = r_pc;

  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign out_fault   = r_out_fault;
  assign fetch_count = r_fetch_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_out_valid   <= 1'b0;
      r_out_instr   <= 32'h0;
      r_out_pc      <= 64'h0;
      r_out_fault   <= 1'b0;
      r_fetch_count <= 64'h0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            // An accepted request still owes us a response that must be drained.
            r_state <= w_req_fire ? ST_DRAIN : ST_REQ;
          end else if (!w_aligned) begin
            r_out_valid <= 1'b1;
            r_out_fault <= 1'b1;
            r_out_instr <= C_NOP;
            r_out_pc    <= r_pc;
            r_state     <= ST_HOLD;
          end else if (ibus.ireq_ready) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= ibus.iresp_valid ? ST_REQ : ST_DRAIN;
          end else if (ibus.iresp_valid) begin
            r_out_valid <= 1'b1;
            r_out_fault <= 1'b0;
            r_out_instr <= ibus.iresp_data;
            r_out_pc    <= r_pc;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            r_pc        <= redirect_pc;
            r_out_valid <= 1'b0;
            r_state     <= ST_REQ;
          end else if (out_ready) begin
            r_out_valid   <= 1'b0;
            r_fetch_count <= r_fetch_count + 64'd1;
            r_pc          <= r_pc + 64'd4;
            r_state       <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end
          if (ibus.iresp_valid) begin
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit with a latency-programmable memory.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_unit;
  localparam logic [63:0] C_RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_fault;
  logic        out_ready = 1'b0;
  logic [63:0] fetch_count;

  always #5 clk = ~clk;

  fetch_unit_if ibus ();

  fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ibus           (ibus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .out_ready      (out_ready),
    .fetch_count    (fetch_count)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  bit          ready_en = 1'b0;
  int          resp_lat = 1;
  bit          pending = 1'b0;
  int          lat_cnt = 0;
  logic [63:0] pend_addr = 64'h0;
  bit          acc_last = 1'b0;
  logic [63:0] acc_addr_last = 64'h0;
  int          acc_count = 0;
  int          hs_count = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5EED_0003;
  endfunction

  // One clock: drive memory, capture pre-edge view, advance model, score handoffs.
  task automatic step();
    logic        acc;
    logic        resp;
    logic        hs;
    logic [63:0] acc_a;
    exp_t        got;
    exp_t        want;
    #1;
    resp = pending && (lat_cnt == 0);
    ibus.ireq_ready  = ready_en && ibus.ireq_valid;
    ibus.iresp_valid = resp;
    ibus.iresp_data  = resp ? mem_word(pend_addr) : 32'h0;
    #1;
    acc   = ibus.ireq_valid && ibus.ireq_ready;
    acc_a = ibus.ireq_addr;
    hs    = out_valid && out_ready && !redirect_valid && reset;
    got   = {out_pc, out_instr, out_fault};
    @(posedge clk);
    if (resp) pending = 1'b0;
    else if (pending && lat_cnt > 0) lat_cnt--;
    acc_last = acc;
    if (acc) begin
      pending       = 1'b1;
      lat_cnt       = resp_lat - 1;
      pend_addr     = acc_a;
      acc_addr_last = acc_a;
      acc_count++;
    end
    if (hs) begin
      hs_count++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL handoff_unexpected: got pc=%h instr=%h fault=%b, required no handoff",
                 got.pc, got.instr, got.fault);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL handoff: got pc=%h instr=%h fault=%b, required pc=%h instr=%h fault=%b",
                   got.pc, got.instr, got.fault, want.pc, want.instr, want.fault);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0; ready_en = 1'b0;
    pending = 1'b0;
    step(); step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected: got %0d pending entries, required 0", sb.size());
    end
    sb.delete();
    reset = 1'b1;
  endtask

  task automatic wait_accept(output bit ok);
    int n = 0;
    do begin step(); n++; end while (!acc_last && n < 20);
    ok = acc_last;
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin step(); n++; end
    total++;
    if (hs_count < target) begin
      bad++;
      $display("FAIL run_timeout: got %0d handoffs, required %0d", hs_count, target);
    end
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ready_en = 1'b1;
    step(); step(); step();
    total++; if (ibus.ireq_valid !== 1'b0) begin bad++; $display("FAIL rst_ireq_valid: got %b required 0", ibus.ireq_valid); end
    total++; if (ibus.ireq_addr !== C_RESET_PC) begin bad++; $display("FAIL rst_ireq_addr: got %h required %h", ibus.ireq_addr, C_RESET_PC); end
    total++; if ({out_valid, out_fault} !== 2'b00) begin bad++; $display("FAIL rst_out_flags: got %b required 00", {out_valid, out_fault}); end
    total++; if ({out_instr, out_pc} !== 96'h0) begin bad++; $display("FAIL rst_out_data: got %h required 0", {out_instr, out_pc}); end
    total++; if (fetch_count !== 64'h0) begin bad++; $display("FAIL rst_fetch_count: got %h required 0", fetch_count); end
    // A stray response lands in the first cycle after release.
    ready_en = 1'b0; pending = 1'b1; lat_cnt = 0; pend_addr = 64'h8000_0400;
    reset = 1'b1; #1;
    total++; if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, C_RESET_PC}) begin bad++; $display("FAIL rel_first_req: got %b/%h required 1/%h", ibus.ireq_valid, ibus.ireq_addr, C_RESET_PC); end
    step();
    total++; if ({out_valid, ibus.ireq_valid, ibus.ireq_addr} !== {2'b01, C_RESET_PC}) begin bad++; $display("FAIL rel_stray_resp: got ov=%b rv=%b addr=%h required 0/1/%h", out_valid, ibus.ireq_valid, ibus.ireq_addr, C_RESET_PC); end
  endtask

  task automatic test_straight();
    int base;
    do_reset();
    ready_en = 1'b1; resp_lat = 1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      sb.push_back({C_RESET_PC + 64'(4 * i), mem_word(C_RESET_PC + 64'(4 * i)), 1'b0});
    base = hs_count;
    run_until(base + 4, 40);
    out_ready = 1'b0;
    total++; if (fetch_count !== 64'd4) begin bad++; $display("FAIL straight_count: got %0d required 4", fetch_count); end
  endtask

  task automatic test_backpressure();
    bit          ok;
    int          k = 0;
    logic [63:0] hold_pc;
    logic [31:0] hold_instr;
    do_reset();
    ready_en = 1'b1; resp_lat = 2; out_ready = 1'b0;
    wait_accept(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_accept: got none required request"); end
    while (!out_valid && k < 10) begin step(); k++; end
    total++; if (k != 2) begin bad++; $display("FAIL bp_latency: got %0d cycles required 2", k); end
    hold_pc = out_pc; hold_instr = out_instr;
    total++; if ({hold_pc, hold_instr} !== {C_RESET_PC, mem_word(C_RESET_PC)}) begin bad++; $display("FAIL bp_held: got %h/%h required %h/%h", hold_pc, hold_instr, C_RESET_PC, mem_word(C_RESET_PC)); end
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if ({out_valid, ibus.ireq_valid, out_pc, out_instr, fetch_count} !== {2'b10, hold_pc, hold_instr, 64'h0}) begin
        bad++;
        $display("FAIL bp_stall%0d: got ov=%b rv=%b pc=%h instr=%h cnt=%0d required 1/0/%h/%h/0",
                 c, out_valid, ibus.ireq_valid, out_pc, out_instr, fetch_count, hold_pc, hold_instr);
      end
    end
    sb.push_back({C_RESET_PC, mem_word(C_RESET_PC), 1'b0});
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total++; if (fetch_count !== 64'd1) begin bad++; $display("FAIL bp_release_count: got %0d required 1", fetch_count); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    ready_en = 1'b1; resp_lat = 4; out_ready = 1'b1;
    wait_accept(ok);
    redirect_to(64'h8000_1000);
    total++; if (ibus.ireq_valid !== 1'b0) begin bad++; $display("FAIL rw_drain_req: got %b required 0", ibus.ireq_valid); end
    sb.push_back({64'h8000_1000, mem_word(64'h8000_1000), 1'b0});
    wait_accept(ok);
    total++; if (!ok || acc_addr_last !== 64'h8000_1000) begin bad++; $display("FAIL rw_next_addr: got %h required 0000000080001000", acc_addr_last); end
    run_until(hs_count + 1, 40);
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_same();
    bit ok;
    do_reset();
    ready_en = 1'b1; resp_lat = 1; out_ready = 1'b1;
    wait_accept(ok);
    redirect_to(64'h8000_2000);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rs_no_old: got out_valid=%b required 0", out_valid); end
    total++; if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, 64'h8000_2000}) begin bad++; $display("FAIL rs_req: got %b/%h required 1/0000000080002000", ibus.ireq_valid, ibus.ireq_addr); end
    sb.push_back({64'h8000_2000, mem_word(64'h8000_2000), 1'b0});
    run_until(hs_count + 1, 20);
    out_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    int acc0;
    do_reset();
    ready_en = 1'b0; out_ready = 1'b0;
    redirect_to(64'h8000_0002);
    acc0 = acc_count;
    total++; if ({ibus.ireq_valid, out_valid} !== 2'b00) begin bad++; $display("FAIL mis_no_req: got rv=%b ov=%b required 0/0", ibus.ireq_valid, out_valid); end
    ready_en = 1'b1;
    step();
    total++;
    if ({out_valid, out_fault, out_instr, out_pc} !== {2'b11, 32'h0000_0013, 64'h8000_0002}) begin
      bad++;
      $display("FAIL mis_fault: got ov=%b f=%b instr=%h pc=%h required 1/1/00000013/0000000080000002", out_valid, out_fault, out_instr, out_pc);
    end
    total++; if (acc_count != acc0) begin bad++; $display("FAIL mis_bus: got %0d requests required 0", acc_count - acc0); end
    sb.push_back({64'h8000_0002, 32'h0000_0013, 1'b1});
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total++; if (fetch_count !== 64'd1) begin bad++; $display("FAIL mis_count: got %0d required 1", fetch_count); end
  endtask

  task automatic test_redirect_hold();
    int k = 0;
    do_reset();
    ready_en = 1'b1; resp_lat = 1; out_ready = 1'b0;
    while (!out_valid && k < 10) begin step(); k++; end
    out_ready = 1'b1;
    redirect_to(64'h8000_4000);
    out_ready = 1'b0;
    total++;
    if ({out_valid, fetch_count, ibus.ireq_addr} !== {1'b0, 64'h0, 64'h8000_4000}) begin
      bad++;
      $display("FAIL rh_discard: got ov=%b cnt=%0d addr=%h required 0/0/0000000080004000", out_valid, fetch_count, ibus.ireq_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    do_reset();
    ready_en = 1'b0; resp_lat = 3; out_ready = 1'b1;
    redirect_to(64'h8000_0100);
    ready_en = 1'b1;
    wait_accept(ok);
    reset = 1'b0; #1;
    total++; if ({ibus.ireq_valid, out_valid} !== 2'b00) begin bad++; $display("FAIL riw_abandon: got rv=%b ov=%b required 0/0", ibus.ireq_valid, out_valid); end
    step(); step();
    total++;
    if ({ibus.ireq_addr, out_instr, out_pc, out_fault, fetch_count} !== {C_RESET_PC, 32'h0, 64'h0, 1'b0, 64'h0}) begin
      bad++;
      $display("FAIL riw_reset_vals: got addr=%h instr=%h pc=%h f=%b cnt=%0d required %h/0/0/0/0", ibus.ireq_addr, out_instr, out_pc, out_fault, fetch_count, C_RESET_PC);
    end
    reset = 1'b1; #1;
    total++; if ({ibus.ireq_valid, ibus.ireq_addr} !== {1'b1, C_RESET_PC}) begin bad++; $display("FAIL riw_first_req: got %b/%h required 1/%h", ibus.ireq_valid, ibus.ireq_addr, C_RESET_PC); end
    sb.push_back({C_RESET_PC, mem_word(C_RESET_PC), 1'b0});
    run_until(hs_count + 1, 20);
    out_ready = 1'b0;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    ready_en = 1'b0;
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    ready_en = 1'b1; resp_lat = 1; out_ready = 1'b1;
    sb.push_back({64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC), 1'b0});
    sb.push_back({64'h0, mem_word(64'h0), 1'b0});
    run_until(hs_count + 2, 20);
    out_ready = 1'b0;
    total++; if (fetch_count !== 64'd2) begin bad++; $display("FAIL wrap_count: got %0d required 2", fetch_count); end
  endtask

  initial begin
    ibus.ireq_ready = 1'b0; ibus.iresp_valid = 1'b0; ibus.iresp_data = 32'h0;
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same();
    test_misaligned();
    test_redirect_hold();
    test_reset_in_wait();
    test_pc_wrap();
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low; 0 = in reset.
REQ-004 Port: ireq_valid  out  1  instruction-bus read request.
REQ-005 Port: ireq_addr  out  64  request address, equals current pc.
REQ-006 Port: ireq_ready  in  1  bus accepted request this cycle.
REQ-007 Port: iresp_valid  in  1  read data returned this cycle.
REQ-008 Port: iresp_data  in  32  returned instruction word.
REQ-009 Port: redirect_valid  in  1  branch/jump/trap/mret redirect.
REQ-010 Port: redirect_pc  in  64  redirect target.
REQ-011 Port: out_valid  out  1  instruction available to decode.
REQ-012 Port: out_instr  out  32  instruction word fed to the decoder instr input.
REQ-013 Port: out_pc  out  64  pc of out_instr.
REQ-014 Port: out_fault  out  1  instruction-address-misaligned fault on out_pc.
REQ-015 Port: out_ready  in  1  decode accepts out_* this cycle.
REQ-016 Port: fetch_count  out  64  number of instructions handed to decode.

Function
REQ-017 States SHALL be REQ, WAIT, HOLD, DRAIN; at most one bus transaction outstanding.
REQ-018 REQ: ireq_valid=1 when pc[1:0]==0; on ireq_ready -> WAIT; pc and ireq_addr SHALL stay stable while waiting unless redirected.
REQ-019 REQ with pc[1:0]!=0: no bus request; next cycle out_valid=1, out_fault=1, out_instr=32'h0000_0013, out_pc=pc -> HOLD.
REQ-020 WAIT: on iresp_valid, out_instr<=iresp_data, out_pc<=pc, out_fault<=0, out_valid<=1 -> HOLD; latency from ireq_ready to out_valid is response latency + 1 cycle.
REQ-021 HOLD: out_* SHALL stay stable while out_ready=0; on out_ready: out_valid<=0, fetch_count+=1, pc<=pc+4 (64-bit wrap) -> REQ.
REQ-022 Redirect SHALL take priority over every other event; pc<=redirect_pc in all cases.
REQ-023 Redirect in REQ without ireq_ready -> REQ at new pc next cycle (request withdrawal is permitted on this bus).
REQ-024 Redirect in REQ with ireq_ready same cycle -> DRAIN.
REQ-025 Redirect in WAIT without iresp_valid -> DRAIN; with iresp_valid same cycle -> data discarded, REQ.
REQ-026 Redirect in HOLD: held instruction discarded, out_valid<=0, fetch_count unchanged even if out_ready=1 -> REQ.
REQ-027 DRAIN: ireq_valid=0; on iresp_valid data discarded -> REQ; redirect in DRAIN updates pc only, stays DRAIN unless iresp_valid same cycle (then REQ).
REQ-028 out_valid SHALL never be 1 for a discarded response; no response outside WAIT/DRAIN shall alter state.
REQ-029 fetch_count SHALL wrap at 2^64 silently and count faulted entries.

Reset
REQ-030 While reset=0: ireq_valid=0, ireq_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_fault=0, fetch_count=0, pc=RESET_PC, state=REQ.
REQ-031 Reset assertion mid-transaction SHALL abandon it immediately; first cycle after release drives ireq_valid=1, ireq_addr=RESET_PC.
REQ-032 Any response arriving in the first cycle after release SHALL be ignored (state REQ).

Verification
REQ-033 Straight line: ready/response 1-cycle, out_ready=1, memory 0x80000000..0x8000000C -> four instructions, out_pc 0x80000000,+4,+8,+C, fetch_count=4.
REQ-034 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_instr/out_pc unchanged, ireq_valid=0, no fetch_count increment.
REQ-035 Redirect in WAIT to 0x80001000, response arrives 3 cycles later -> response dropped, next request addr 0x80001000, next out_pc 0x80001000.
REQ-036 Redirect and iresp_valid same cycle in WAIT -> no out_valid for old data, request to redirect_pc the following cycle.
REQ-037 Redirect to 0x80000002 -> no bus request, out_valid=1, out_fault=1, out_instr=0x00000013, out_pc=0x80000002.
REQ-038 Reset asserted in WAIT, response returned during/after release -> outputs at reset values, first request at 0x80000000, stale data never presented.
